// File: rtl/fpcvt_arbiter.sv
// Purpose : two-requester round-robin arbiter feeding a 12-bit two's-complement to 1/3/4 mini-float converter.
// Latency : gnt pulses the cycle after the request is sampled; out_valid rises one cycle after gnt.
// Backpressure: result is held in DONE until out_ack; pending requests wait (never dropped) while busy.
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   req0/d0, req1/d1   - requests and 12-bit operands, held until the matching gnt
//   gnt0, gnt1         - one-cycle capture pulses (mutually exclusive)
//   out_valid/out_id   - result valid and index of the requester it belongs to
//   out_s/out_e/out_f  - sign, 3-bit exponent, 4-bit significand
//   out_ack            - consumer accept, only looked at while out_valid is high
module fpcvt_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [11:0] d0,
    input  logic        req1,
    input  logic [11:0] d1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        out_valid,
    output logic        out_id,
    output logic        out_s,
    output logic [2:0]  out_e,
    output logic [3:0]  out_f,
    input  logic        out_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [11:0] lat_d_q, lat_d_d;
    logic        lat_id_q, lat_id_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        out_valid_q, out_valid_d;
    logic        out_id_q, out_id_d;
    logic        out_s_q, out_s_d;
    logic [2:0]  out_e_q, out_e_d;
    logic [3:0]  out_f_q, out_f_d;

    // ------------------------------------------------------------------
    // Conversion of the latched operand
    // ------------------------------------------------------------------
    logic [11:0] mag;
    logic [11:0] shifted;
    logic [3:0]  pos;
    logic        found;
    logic        rnd;
    logic [2:0]  raw_e;
    logic [3:0]  raw_f;
    logic        cv_s;
    logic [2:0]  cv_e;
    logic [3:0]  cv_f;

    always_comb begin
        mag     = lat_d_q;
        shifted = 12'd0;
        pos     = 4'd0;
        found   = 1'b0;
        rnd     = 1'b0;
        raw_e   = 3'd0;
        raw_f   = 4'd0;
        cv_s    = lat_d_q[11];
        cv_e    = 3'd0;
        cv_f    = 4'd0;

        // -2048 has no positive twin in 12 bits; clamp it to the largest magnitude.
        if (lat_d_q == 12'h800) begin
            mag = 12'd2047;
        end else if (lat_d_q[11]) begin
            mag = ~lat_d_q + 12'd1;
        end

        // Highest set bit in [10:4]; later iterations win, so pos ends on the leading one.
        // Bit 11 of the magnitude is always clear after the clamp above.
        for (int i = 4; i <= 10; i++) begin
            if (mag[i]) begin
                pos   = 4'(i);
                found = 1'b1;
            end
        end

        if (found) begin
            // Align so the leading one lands at bit 4 and the round bit at bit 0.
            shifted = mag >> (pos - 4'd4);
            raw_e   = 3'(pos - 4'd3);
            raw_f   = shifted[4:1];
            rnd     = shifted[0];
        end else begin
            raw_e   = 3'd0;
            raw_f   = mag[3:0];
            rnd     = 1'b0;
        end

        cv_e = raw_e;
        cv_f = raw_f;
        if (rnd) begin
            if (raw_f != 4'd15) begin
                cv_f = raw_f + 4'd1;
            end else if (raw_e != 3'd7) begin
                // Significand overflow renormalises to 1000 with a bumped exponent.
                cv_f = 4'd8;
                cv_e = raw_e + 3'd1;
            end else begin
                cv_f = 4'd15;
                cv_e = 3'd7;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration and sequencing
    // ------------------------------------------------------------------
    logic win;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lat_d_d     = lat_d_q;
        lat_id_d    = lat_id_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_s_d     = out_s_q;
        out_e_d     = out_e_q;
        out_f_d     = out_f_q;
        win         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Tie goes to the pointer side; a lone request always wins.
                    win      = (req0 && req1) ? ptr_q : req1;
                    lat_id_d = win;
                    lat_d_d  = win ? d1 : d0;
                    gnt0_d   = ~win;
                    gnt1_d   = win;
                    ptr_d    = ~win;
                    state_d  = CONV;
                end
            end
            CONV: begin
                out_s_d     = cv_s;
                out_e_d     = cv_e;
                out_f_d     = cv_f;
                out_id_d    = lat_id_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                // Returning to IDLE costs one edge, so no grant coincides with the ack.
                if (out_ack) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            lat_d_q     <= 12'd0;
            lat_id_q    <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_s_q     <= 1'b0;
            out_e_q     <= 3'd0;
            out_f_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lat_d_q     <= lat_d_d;
            lat_id_q    <= lat_id_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_s_q     <= out_s_d;
            out_e_q     <= out_e_d;
            out_f_q     <= out_f_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_s     = out_s_q;
    assign out_e     = out_e_q;
    assign out_f     = out_f_q;

endmodule

// File: doc/fpcvt_arbiter.md
FPCVT_ARBITER -- requirements
Module: fpcvt_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req0  input  1  requester 0 conversion request; held high until gnt0 is seen.
REQ-005 d0  input  12  requester 0 two's-complement operand; stable while req0 is high.
REQ-006 req1  input  1  requester 1 conversion request; same rules as req0.
REQ-007 d1  input  12  requester 1 operand.
REQ-008 gnt0  output  1  one-cycle pulse: d0 captured.
REQ-009 gnt1  output  1  one-cycle pulse: d1 captured.
REQ-010 out_valid  output  1  result registers hold a valid conversion.
REQ-011 out_id  output  1  requester index of the current result.
REQ-012 out_s  output  1  sign bit.
REQ-013 out_e  output  3  exponent, 0-7.
REQ-014 out_f  output  4  significand, 0-15.
REQ-015 out_ack  input  1  consumer accepts the result; sampled only while out_valid=1.

Function
REQ-016 The FSM SHALL have the states IDLE, CONV and DONE.
REQ-017 IDLE: on a clock edge with req0|req1 high, latch the winner's operand and index, assert the matching gnt for exactly the next cycle, and go to CONV; otherwise remain in IDLE.
REQ-018 Arbitration SHALL be round-robin using a 1-bit pointer, reset value 0. On a single request, that requester wins. On simultaneous requests, the pointer side wins. After each grant, the pointer SHALL point to the other requester.
REQ-019 CONV (1 cycle): register the conversion of the latched operand into out_s/out_e/out_f and the latched index into out_id; set out_valid=1; go to DONE.
REQ-020 Latency: gnt is high in cycle k+1 and out_valid rises in cycle k+2, where k is the edge on which the request was sampled in IDLE.
REQ-021 DONE: hold all outputs stable until the edge sampling out_ack=1. At that edge, clear out_valid and go to IDLE. No grant SHALL be issued on that edge; the earliest next grant is one edge later.
REQ-022 out_ack in IDLE or CONV SHALL be ignored. Requests arriving in CONV or DONE SHALL stay pending and SHALL NOT be dropped.
REQ-023 Sign: S = D[11]. Magnitude M = |D|, except D = 12'h800, for which M = 2047.
REQ-024 Let lz be the number of leading zeros of the 12-bit M. For lz 1-7: E = 8-lz; F = the 4 bits starting at the leading one; round bit R = the next lower bit.
REQ-025 For lz >= 8, including M = 0: E = 0, F = M[3:0], R = 0.
REQ-026 Rounding when R=1:
- F<15: F = F+1.
- F=15 and E<7: F = 8 and E = E+1.
- F=15 and E=7: saturate to E=7, F=15.
REQ-027 At most one conversion SHALL be in flight; gnt0 and gnt1 SHALL never both be high.

Reset
REQ-028 While rst is high, regardless of state:
- FSM = IDLE, pointer = 0.
- gnt0 = gnt1 = 0.
- out_valid = 0, out_id = 0, out_s = 0, out_e = 0, out_f = 0.
- Any latched operand SHALL be discarded.
REQ-029 After rst deasserts, the first sampled request SHALL be arbitrated as in REQ-018 with pointer = 0.

Verification
REQ-030 Reset asserted during DONE with out_valid=1 -> all outputs 0 immediately (asynchronous); after release, req1 alone is granted normally.
REQ-031 req0=1, d0=12'h07D -> gnt0 pulse, then out_valid=1, out_id=0, S=0, E=4, F=8 (round overflow); outputs stay until out_ack.
REQ-032 req0 and req1 high on the same edge after reset, d0=12'h800, d1=12'h1A6 -> requester 0 served first with S=1, E=7, F=15 (saturation). After out_ack, requester 1 is served with out_id=1, S=0, E=5, F=13.
REQ-033 out_ack held low for 10 cycles in DONE while req0 is high -> outputs constant, no gnt. After out_ack, gnt0 is issued no earlier than the second edge.
REQ-034 d0=12'h00A, then d0=12'h000 -> E=0, F=10, then S=0, E=0, F=0. An out_ack pulse in IDLE has no effect.
REQ-035 req0 and req1 continuously high for 4 transactions -> grants alternate 0, 1, 0, 1.
